// File: rtl/chorus_pkg.sv
// chorus_pkg: shared widths, FSM states and saturation limits for the chorus mixer
package chorus_pkg;
  localparam int WIDTH = 16;
  localparam int GAIN_W = 8;
  localparam int ACC_W = WIDTH + GAIN_W + 2;
  localparam int SAT_MAX = (2 ** (WIDTH - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (WIDTH - 1));
  typedef enum logic [1:0] {IDLE, MUL_DRY, MUL_WET, OUT} state_t;
endpackage

// File: rtl/shift_add_mac.sv
// shift_add_mac: serial multiply-accumulate, one conditional shifted add per step
module shift_add_mac #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 26,
  parameter int N = 9,
  parameter int CW = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    step,
  input  logic [WIDTH-1:0]        operand,
  input  logic                    coef_bit,
  output logic signed [ACC_W-1:0] acc,
  output logic [CW-1:0]           cnt
);
  logic signed [ACC_W-1:0] ext;
  assign ext = {{(ACC_W - WIDTH){operand[WIDTH-1]}}, operand};
  // counter wraps after N steps so the second operand starts again at bit 0
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (step) begin
      if (coef_bit) acc <= acc + (ext << cnt);
      cnt <= (cnt == CW'(N - 1)) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/chorus_mixer.sv
// chorus_mixer: ramps wet gain, blends dry/wet serially, rounds and saturates one sample per strobe
module chorus_mixer #(
  parameter int WIDTH = chorus_pkg::WIDTH,
  parameter int GAIN_W = chorus_pkg::GAIN_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic signed [WIDTH-1:0] dryIn,
  input  logic signed [WIDTH-1:0] wetIn,
  input  logic [GAIN_W-1:0]       mixTarget,
  output logic                    ready,
  output logic signed [WIDTH-1:0] dataOut,
  output logic                    valid,
  output logic                    overrun
);
  import chorus_pkg::*;
  localparam int AW = WIDTH + GAIN_W + 2;
  localparam int CW = $clog2(GAIN_W + 1);
  localparam logic signed [AW-1:0] HI = AW'(SAT_MAX);
  localparam logic signed [AW-1:0] LO = AW'(SAT_MIN);
  state_t state, nxt;
  logic [GAIN_W-1:0] g;
  logic [WIDTH-1:0] dry_r, wet_r;
  logic [GAIN_W:0] dry_c, wet_c;
  logic [CW-1:0] cnt;
  logic signed [AW-1:0] acc, sum, rnd;
  logic accept, last, mul_dry;
  assign accept = enable && state == IDLE;
  assign mul_dry = state == MUL_DRY;
  assign last = cnt == CW'(GAIN_W);
  assign dry_c = (GAIN_W + 1)'(2 ** GAIN_W) - {1'b0, g};
  assign wet_c = {1'b0, g};
  assign ready = state == IDLE;
  assign sum = acc + AW'(2 ** (GAIN_W - 1));
  assign rnd = sum >>> GAIN_W;
  shift_add_mac #(.WIDTH(WIDTH), .ACC_W(AW), .N(GAIN_W + 1), .CW(CW)) u_mac (
    .clk(clk),
    .reset(reset),
    .clear(accept),
    .step(mul_dry || state == MUL_WET),
    .operand(mul_dry ? dry_r : wet_r),
    .coef_bit(mul_dry ? dry_c[cnt] : wet_c[cnt]),
    .acc(acc),
    .cnt(cnt)
  );
  always_comb begin
    nxt = state;
    if (accept) nxt = MUL_DRY;
    else if (mul_dry && last) nxt = MUL_WET;
    else if (state == MUL_WET && last) nxt = OUT;
    else if (state == OUT) nxt = IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  // gain steps once per accepted sample; the stepped value weights that sample
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      g <= '0;
      dry_r <= '0;
      wet_r <= '0;
      dataOut <= '0;
      valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      valid <= state == OUT;
      if (enable && state != IDLE) overrun <= 1'b1;
      if (accept) begin
        dry_r <= dryIn;
        wet_r <= wetIn;
        g <= (g < mixTarget) ? g + 1'b1 : (g > mixTarget) ? g - 1'b1 : g;
      end
      if (state == OUT)
        dataOut <= (rnd > HI) ? HI[WIDTH-1:0] : (rnd < LO) ? LO[WIDTH-1:0] : rnd[WIDTH-1:0];
    end
endmodule

// File: tb/tb_chorus_mixer.sv
// tb_chorus_mixer: directed scenario tests for chorus_mixer with hand-computed results
module tb_chorus_mixer;
  logic clk = 0;
  logic reset, enable, ready, valid, overrun;
  logic signed [15:0] dryIn, wetIn, dataOut;
  logic [7:0] mixTarget;
  int checks = 0, errors = 0;

  chorus_mixer dut (
    .clk(clk), .reset(reset), .enable(enable), .dryIn(dryIn), .wetIn(wetIn),
    .mixTarget(mixTarget), .ready(ready), .dataOut(dataOut), .valid(valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic signed [15:0] ref_mix(input int d, input int w, input int g);
    longint v;
    v = (longint'(d) * (256 - g) + longint'(w) * g + 128) >>> 8;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return 16'(v);
  endfunction

  task automatic do_reset();
    reset = 1; enable = 0; dryIn = 0; wetIn = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;
  endtask

  task automatic run_sample(input logic signed [15:0] d, input logic signed [15:0] w,
                            output logic signed [15:0] o, output int lat);
    @(negedge clk);
    dryIn = d; wetIn = w; enable = 1;
    @(posedge clk); #1 enable = 0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1 lat++;
      if (valid) break;
    end
    o = dataOut;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({ready, valid, overrun} !== 3'b100 || dataOut !== 16'sd0) begin
      errors++;
      $display("FAIL reset: ready/valid/overrun=%b dataOut=%0d, expected 100 and 0", {ready, valid, overrun}, dataOut);
    end
  endtask

  task automatic test_zero_gain();
    logic signed [15:0] o; int lat;
    do_reset(); mixTarget = 0;
    run_sample(1000, -1000, o, lat);
    checks++;
    if (lat !== 19) begin errors++; $display("FAIL zero_gain_latency: got %0d, expected 19", lat); end
    checks++;
    if (o !== 16'sd1000) begin errors++; $display("FAIL zero_gain_data: got %0d, expected 1000", o); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL zero_gain_ready: got %b, expected 1", ready); end
    @(posedge clk); #1;
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL zero_gain_valid_pulse: got %b, expected 0", valid); end
  endtask

  task automatic test_ramp();
    logic signed [15:0] o; int lat;
    do_reset(); mixTarget = 128;
    run_sample(256, 0, o, lat);
    checks++;
    if (o !== 16'sd255) begin errors++; $display("FAIL ramp_first: got %0d, expected 255", o); end
    for (int i = 0; i < 127; i++) run_sample(256, 0, o, lat);
    checks++;
    if (o !== 16'sd128) begin errors++; $display("FAIL ramp_128: got %0d, expected 128", o); end
    run_sample(0, 256, o, lat);
    checks++;
    if (o !== 16'sd128) begin errors++; $display("FAIL ramp_hold: got %0d, expected 128", o); end
  endtask

  task automatic test_extreme();
    logic signed [15:0] o; int lat;
    do_reset(); mixTarget = 255;
    for (int i = 0; i < 254; i++) run_sample(0, 0, o, lat);
    run_sample(-32768, 32767, o, lat);
    checks++;
    if (o !== 16'sd32511) begin errors++; $display("FAIL extreme: got %0d, expected 32511", o); end
    mixTarget = 0;
    for (int k = 254; k >= 252; k--) begin
      run_sample(0, 256, o, lat);
      checks++;
      if (o !== 16'(k)) begin errors++; $display("FAIL ramp_down: got %0d, expected %0d", o, k); end
    end
  endtask

  task automatic test_overrun();
    logic signed [15:0] o; int lat, nvalid;
    do_reset(); mixTarget = 10;
    @(negedge clk); dryIn = 500; wetIn = -7; enable = 1;
    @(negedge clk); enable = 0;
    repeat (4) @(negedge clk);
    dryIn = -30000; wetIn = 30000; enable = 1;
    @(negedge clk); enable = 0;
    nvalid = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (valid) begin nvalid++; o = dataOut; end
    end
    checks++;
    if (nvalid !== 1) begin errors++; $display("FAIL overrun_valids: got %0d, expected 1", nvalid); end
    checks++;
    if (o !== 16'sd498) begin errors++; $display("FAIL overrun_data: got %0d, expected 498", o); end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b, expected 1", overrun); end
    run_sample(0, 256, o, lat);
    checks++;
    if (o !== 16'sd2) begin errors++; $display("FAIL overrun_gain: got %0d, expected 2", o); end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b, expected 1", overrun); end
  endtask

  task automatic test_reset_abort();
    logic signed [15:0] o; int lat, nvalid;
    @(negedge clk); dryIn = 0; wetIn = 256; enable = 1;
    @(negedge clk); enable = 0;
    repeat (9) @(posedge clk);
    #2 reset = 1;
    #1;
    checks++;
    if ({ready, overrun} !== 2'b10 || dataOut !== 16'sd0) begin
      errors++;
      $display("FAIL abort_immediate: ready/overrun=%b dataOut=%0d, expected 10 and 0", {ready, overrun}, dataOut);
    end
    @(negedge clk) reset = 0;
    nvalid = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (valid) nvalid++;
    end
    checks++;
    if (nvalid !== 0 || dataOut !== 16'sd0) begin
      errors++;
      $display("FAIL abort_no_valid: valids=%0d dataOut=%0d, expected 0 and 0", nvalid, dataOut);
    end
    mixTarget = 5;
    run_sample(0, 256, o, lat);
    checks++;
    if (o !== 16'sd1) begin errors++; $display("FAIL abort_next: got %0d, expected 1", o); end
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] o, d, w; int lat, gm;
    do_reset(); mixTarget = 37; gm = 0;
    for (int i = 0; i < 50; i++) begin
      d = 16'(i * 7919 - 20000);
      w = 16'(9000 - i * 3571);
      gm = gm < 37 ? gm + 1 : gm;
      run_sample(d, w, o, lat);
      checks++;
      if (o !== ref_mix(d, w, gm) || lat !== 19) begin
        errors++;
        $display("FAIL b2b_%0d: got %0d lat %0d, expected %0d lat 19", i, o, lat, ref_mix(d, w, gm));
      end
    end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b, expected 0", overrun); end
  endtask

  initial begin
    mixTarget = 0;
    test_reset();
    test_zero_gain();
    test_ramp();
    test_extreme();
    test_overrun();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
